fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 149 ++++++++++++++
 tb/tb_fetch_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch unit for the CPU15 core.
//
// Owns the program counter and drives a synchronous instruction ROM. The ROM
// registers its address and returns data one cycle later. Returned words go
// into a small prefetch FIFO and are handed to decode over a valid/ready
// handshake. A redirect loads a new PC and flushes everything queued or in
// flight. Clearing enable stops new fetches, but an outstanding read still
// lands and the FIFO keeps draining.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset_n      synchronous active-low reset
//   enable       1 = new ROM fetches may be issued
//   rom_addr     ROM address (combinational: redirect target or current PC)
//   rom_q        ROM data for the address presented in the previous cycle
//   redirect     load redirect_pc and flush the queue
//   redirect_pc  redirect target
//   instr_valid  FIFO head valid
//   instr_ready  decode accepts the head
//   instr_data   head instruction word
//   instr_pc     address of the head instruction
//   q_count      number of FIFO entries

module fetch_queue #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 15,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DATA_W-1:0]      rom_q,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [DATA_W-1:0]      instr_data,
  output logic [ADDR_W-1:0]      instr_pc,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);
  // One bit wider than the count so count + pending cannot overflow.
  localparam logic [CntW:0]     DepthW  = (CntW + 1)'(DEPTH);

  // Architectural state.
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] pending_pc_q, pending_pc_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  // FIFO storage: one {pc, data} pair per entry.
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic          issue;
  logic          push;
  logic          pop;
  logic [CntW:0] credit;

  // Redirect drives the ROM directly so the target is fetched in the same
  // cycle; this is what keeps the redirect penalty at two cycles.
  assign rom_addr = redirect ? redirect_pc : pc_q;

  // Entries held plus the one read in flight must leave room for the word we
  // are about to request, so a push can never find the FIFO full.
  assign credit = {1'b0, count_q} + {{CntW{1'b0}}, pending_q};

  assign issue = reset_n & (redirect | (enable & (credit < DepthW)));

  // Redirect squashes both the word arriving from the ROM and any pop.
  assign push = pending_q & ~redirect;
  assign pop  = instr_valid & instr_ready & ~redirect;

  // Fetch-side next state.
  always_comb begin
    pc_d         = pc_q;
    pending_d    = 1'b0;
    pending_pc_d = pending_pc_q;
    if (issue) begin
      pending_d    = 1'b1;
      pending_pc_d = rom_addr;
      pc_d         = rom_addr + ADDR_W'(1);
    end
  end

  // Queue-side next state.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q         <= ResetPc;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      // Storage is cleared so the head reads as zero right after reset.
      pc_mem_q     <= '{default: '0};
      data_mem_q   <= '{default: '0};
    end else begin
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= pending_pc_q;
        data_mem_q[wr_ptr_q] <= rom_q;
      end
    end
  end

  assign instr_valid = (count_q != '0);
  assign instr_data  = data_mem_q[rd_ptr_q];
  assign instr_pc    = pc_mem_q[rd_ptr_q];
  assign q_count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 15;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned RESET_PC = 0;
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic [CNT_W-1:0]  q_count;

  fetch_queue #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_data (instr_data),
    .instr_pc   (instr_pc),
    .q_count    (q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) ^ 15'h5A5;
  endfunction

  // Synchronous ROM: registered address, data one cycle later.
  always @(posedge clk) rom_q <= rom_word(rom_addr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched words plus one in-flight read.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mq[$];
  bit                m_known = 1'b0;
  bit                m_pend  = 1'b0;
  logic [ADDR_W-1:0] m_ppc;
  logic [ADDR_W-1:0] m_pc;

  // Called at the negedge: compare outputs, then advance to the next edge.
  task automatic model_cycle();
    int                n;
    entry_t            e;
    logic [ADDR_W-1:0] a;
    if (m_known) begin
      check("m_valid", 32'(instr_valid), 32'(mq.size() != 0));
      check("m_count", 32'(q_count), 32'(mq.size()));
      check("m_rom_addr", 32'(rom_addr), 32'(redirect ? redirect_pc : m_pc));
      if (mq.size() != 0) begin
        check("m_head_pc", 32'(instr_pc), 32'(mq[0].pc));
        check("m_head_data", 32'(instr_data), 32'(mq[0].data));
      end
    end
    if (!reset_n) begin
      mq.delete();
      m_pend  = 1'b0;
      m_pc    = ADDR_W'(RESET_PC);
      m_known = 1'b1;
    end else if (m_known) begin
      n = mq.size();
      if (redirect) begin
        mq.delete();
      end else begin
        if (n != 0 && instr_ready) void'(mq.pop_front());
        if (m_pend) begin
          e.pc   = m_ppc;
          e.data = rom_word(m_ppc);
          mq.push_back(e);
        end
      end
      if (redirect || (enable && (n + int'(m_pend)) < int'(DEPTH))) begin
        a      = redirect ? redirect_pc : m_pc;
        m_pend = 1'b1;
        m_ppc  = a;
        m_pc   = ADDR_W'((int'(a) + 1) % (1 << ADDR_W));
      end else begin
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic apply(input logic r, input logic e, input logic y, input logic d,
                       input logic [ADDR_W-1:0] p);
    reset_n     = r;
    enable      = e;
    instr_ready = y;
    redirect    = d;
    redirect_pc = p;
    @(negedge clk);
  endtask

  task automatic advance();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic              r, e, y, d;
    logic [ADDR_W-1:0] p;
    bit                c, h;
    logic              v;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] dat;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] a;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, e, y, d, input logic [ADDR_W-1:0] p,
                     input bit c, h, input logic v, input logic [ADDR_W-1:0] pc,
                     input logic [DATA_W-1:0] dat, input logic [CNT_W-1:0] cnt,
                     input logic [ADDR_W-1:0] a);
    vec_t t;
    t.r = r; t.e = e; t.y = y; t.d = d; t.p = p;
    t.c = c; t.h = h; t.v = v; t.pc = pc; t.dat = dat; t.cnt = cnt; t.a = a;
    tbl.push_back(t);
  endtask

  vec_t t;

  initial begin
    reset_n = 1'b0; enable = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;

    //   r  e  y  d  rpc    c  h  v  pc     data     cnt a
    // Startup
    add(0, 1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 15'h000, 0, 8'h00);
    add(0, 1, 1, 0, 8'h00, 1, 1, 0, 8'h00, 15'h000, 0, 8'h00);
    add(1, 1, 1, 0, 8'h00, 1, 1, 0, 8'h00, 15'h000, 0, 8'h00);
    add(1, 1, 1, 0, 8'h00, 1, 0, 0, 8'h00, 15'h000, 0, 8'h01);
    add(1, 1, 1, 0, 8'h00, 1, 1, 1, 8'h00, 15'h5A5, 1, 8'h02);
    add(1, 1, 1, 0, 8'h00, 1, 1, 1, 8'h01, 15'h5A4, 1, 8'h03);
    add(1, 1, 1, 0, 8'h00, 1, 1, 1, 8'h02, 15'h5A7, 1, 8'h04);
    // Reset, then backpressure from cycle 2
    add(0, 1, 1, 0, 8'h00, 1, 1, 1, 8'h03, 15'h5A6, 1, 8'h05);
    add(1, 1, 1, 0, 8'h00, 1, 1, 0, 8'h00, 15'h000, 0, 8'h00);
    add(1, 1, 1, 0, 8'h00, 1, 0, 0, 8'h00, 15'h000, 0, 8'h01);
    add(1, 1, 0, 0, 8'h00, 1, 1, 1, 8'h00, 15'h5A5, 1, 8'h02);
    add(1, 1, 0, 0, 8'h00, 1, 1, 1, 8'h00, 15'h5A5, 2, 8'h03);
    add(1, 1, 0, 0, 8'h00, 1, 1, 1, 8'h00, 15'h5A5, 3, 8'h04);
    add(1, 1, 0, 0, 8'h00, 1, 1, 1, 8'h00, 15'h5A5, 4, 8'h04);
    add(1, 1, 0, 0, 8'h00, 1, 1, 1, 8'h00, 15'h5A5, 4, 8'h04);
    add(1, 1, 1, 0, 8'h00, 1, 1, 1, 8'h00, 15'h5A5, 4, 8'h04);
    add(1, 1, 1, 0, 8'h00, 1, 1, 1, 8'h01, 15'h5A4, 3, 8'h04);
    add(1, 1, 1, 0, 8'h00, 1, 1, 1, 8'h02, 15'h5A7, 2, 8'h05);
    add(1, 1, 1, 0, 8'h00, 1, 1, 1, 8'h03, 15'h5A6, 2, 8'h06);
    add(1, 1, 1, 0, 8'h00, 1, 1, 1, 8'h04, 15'h5A1, 2, 8'h07);
    // Redirect to 0x80
    add(1, 1, 1, 1, 8'h80, 1, 1, 1, 8'h05, 15'h5A0, 2, 8'h80);
    add(1, 1, 1, 0, 8'h00, 1, 0, 0, 8'h00, 15'h000, 0, 8'h81);
    add(1, 1, 1, 0, 8'h00, 1, 1, 1, 8'h80, 15'h525, 1, 8'h82);
    add(1, 1, 1, 0, 8'h00, 1, 1, 1, 8'h81, 15'h524, 1, 8'h83);
    // Redirect to 0xFE, PC wrap
    add(1, 1, 1, 1, 8'hFE, 1, 1, 1, 8'h82, 15'h527, 1, 8'hFE);
    add(1, 1, 1, 0, 8'h00, 1, 0, 0, 8'h00, 15'h000, 0, 8'hFF);
    add(1, 1, 1, 0, 8'h00, 1, 1, 1, 8'hFE, 15'h55B, 1, 8'h00);
    add(1, 1, 1, 0, 8'h00, 1, 1, 1, 8'hFF, 15'h55A, 1, 8'h01);
    add(1, 1, 1, 0, 8'h00, 1, 1, 1, 8'h00, 15'h5A5, 1, 8'h02);
    // Redirect to 0x40 with ready=0, then drop enable at count=2, pending=1
    add(1, 1, 0, 1, 8'h40, 1, 1, 1, 8'h01, 15'h5A4, 1, 8'h40);
    add(1, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 15'h000, 0, 8'h41);
    add(1, 1, 0, 0, 8'h00, 1, 1, 1, 8'h40, 15'h5E5, 1, 8'h42);
    add(1, 0, 0, 0, 8'h00, 1, 1, 1, 8'h40, 15'h5E5, 2, 8'h43);
    add(1, 0, 0, 0, 8'h00, 1, 1, 1, 8'h40, 15'h5E5, 3, 8'h43);
    add(1, 0, 0, 0, 8'h00, 1, 1, 1, 8'h40, 15'h5E5, 3, 8'h43);
    // Redirect while disabled still fetches the target
    add(1, 0, 0, 1, 8'h10, 1, 1, 1, 8'h40, 15'h5E5, 3, 8'h10);
    add(1, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 15'h000, 0, 8'h11);
    add(1, 0, 0, 0, 8'h00, 1, 1, 1, 8'h10, 15'h5B5, 1, 8'h11);
    add(1, 1, 0, 0, 8'h00, 1, 1, 1, 8'h10, 15'h5B5, 1, 8'h11);
    add(1, 1, 0, 0, 8'h00, 1, 1, 1, 8'h10, 15'h5B5, 1, 8'h12);
    add(1, 1, 0, 0, 8'h00, 1, 1, 1, 8'h10, 15'h5B5, 2, 8'h13);
    // Reset mid-stream with three queued words
    add(0, 1, 0, 0, 8'h00, 1, 1, 1, 8'h10, 15'h5B5, 3, 8'h14);
    add(1, 1, 1, 0, 8'h00, 1, 1, 0, 8'h00, 15'h000, 0, 8'h00);
    add(1, 1, 1, 0, 8'h00, 1, 0, 0, 8'h00, 15'h000, 0, 8'h01);
    add(1, 1, 1, 0, 8'h00, 1, 1, 1, 8'h00, 15'h5A5, 1, 8'h02);
    add(1, 1, 1, 0, 8'h00, 1, 1, 1, 8'h01, 15'h5A4, 1, 8'h03);

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      apply(t.r, t.e, t.y, t.d, t.p);
      if (t.c) begin
        check($sformatf("row%0d_valid", i), 32'(instr_valid), 32'(t.v));
        check($sformatf("row%0d_count", i), 32'(q_count), 32'(t.cnt));
        check($sformatf("row%0d_rom_addr", i), 32'(rom_addr), 32'(t.a));
        if (t.h) begin
          check($sformatf("row%0d_pc", i), 32'(instr_pc), 32'(t.pc));
          check($sformatf("row%0d_data", i), 32'(instr_data), 32'(t.dat));
        end
      end
      advance();
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(99) != 0),
            ($urandom_range(9) < 8),
            ($urandom_range(9) < 6),
            ($urandom_range(11) == 0),
            ADDR_W'($urandom));
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
